// File: rtl/vis_prefetch_pkg.sv
// Shared configuration and state encoding for the visibility prefetch master.
// Optional pipelined burst mode is selected with VIS_PREFETCH_BURST_EN.
package vis_prefetch_pkg;
  localparam int unsigned DEF_ACCUM   = 24;
  localparam int unsigned DEF_COUNT   = 2;
  localparam int unsigned DEF_DBITS   = 1;
  localparam int unsigned DEF_BBITS   = 4;
  localparam int unsigned DEF_TBITS   = 4;
  localparam int unsigned DEF_TRATE   = 12;
  localparam int unsigned DEF_NBITS   = 8;
  localparam int unsigned DEF_TIMEOUT = 15;
  localparam int unsigned WBITS       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BURST,
    ST_FINISH
  } state_e;
endpackage

// File: rtl/vis_prefetch_addr.sv
// Nested word/slot/device read-address counter plus sequential buffer index.
module vis_prefetch_addr
  import vis_prefetch_pkg::*;
#(
  parameter int unsigned COUNT = DEF_COUNT,
  parameter int unsigned DBITS = DEF_DBITS,
  parameter int unsigned TBITS = DEF_TBITS,
  parameter int unsigned TRATE = DEF_TRATE,
  parameter int unsigned NBITS = DEF_NBITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic             inc_i,
  output logic [DBITS-1:0] dev_o,
  output logic [TBITS-1:0] slot_o,
  output logic [WBITS-1:0] word_o,
  output logic             last_o,
  output logic [NBITS-1:0] idx_o
);
  localparam logic [DBITS-1:0] DEV_LAST  = DBITS'(COUNT - 1);
  localparam logic [TBITS-1:0] SLOT_LAST = TBITS'(TRATE - 1);

  logic [DBITS-1:0] dev_q, dev_d;
  logic [TBITS-1:0] slot_q, slot_d;
  logic [WBITS-1:0] word_q, word_d;
  logic [NBITS-1:0] idx_q, idx_d;

  always_comb begin
    dev_d  = dev_q;
    slot_d = slot_q;
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      dev_d  = '0;
      slot_d = '0;
      word_d = '0;
      idx_d  = '0;
    end else begin
      if (adv_i) begin
        word_d = word_q + 1'b1;
        if (word_q == '1) begin
          if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            dev_d  = (dev_q == DEV_LAST) ? '0 : dev_q + 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      if (inc_i) idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dev_q  <= '0;
      slot_q <= '0;
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      dev_q  <= dev_d;
      slot_q <= slot_d;
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign dev_o  = dev_q;
  assign slot_o = slot_q;
  assign word_o = word_q;
  assign idx_o  = idx_q;
  assign last_o = (dev_q == DEV_LAST) && (slot_q == SLOT_LAST) && (word_q == '1);
endmodule

// File: rtl/vis_prefetch.sv
// Bus master draining one visibility bank from the correlator chain into the readout buffer.
// Define VIS_PREFETCH_BURST_EN for pipelined burst reads; default is one strobe per read.
module vis_prefetch
  import vis_prefetch_pkg::*;
#(
  parameter int unsigned ACCUM   = DEF_ACCUM,
  parameter int unsigned COUNT   = DEF_COUNT,
  parameter int unsigned DBITS   = DEF_DBITS,
  parameter int unsigned BBITS   = DEF_BBITS,
  parameter int unsigned TBITS   = DEF_TBITS,
  parameter int unsigned TRATE   = DEF_TRATE,
  parameter int unsigned ABITS   = DBITS + BBITS + TBITS + WBITS,
  parameter int unsigned NBITS   = DEF_NBITS,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [BBITS-1:0] bank_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  input  logic             ack_i,
  output logic [ABITS-1:0] adr_o,
  input  logic [ACCUM-1:0] dat_i,
  output logic             buf_we_o,
  output logic [NBITS-1:0] buf_adr_o,
  output logic [ACCUM-1:0] buf_dat_o
);
  localparam int unsigned      WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [BBITS-1:0] bank_q, bank_d;
  logic             err_q, err_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             buf_we_q;
  logic [NBITS-1:0] buf_adr_q;
  logic [ACCUM-1:0] buf_dat_q;

  logic             clr, adv, ack_acc, last;
  logic [DBITS-1:0] dev;
  logic [TBITS-1:0] slot;
  logic [WBITS-1:0] word;
  logic [NBITS-1:0] idx;

`ifdef VIS_PREFETCH_BURST_EN
  logic [3:0] out_q, out_d;
  logic       issued_q, issued_d;
`endif

  vis_prefetch_addr #(
    .COUNT(COUNT),
    .DBITS(DBITS),
    .TBITS(TBITS),
    .TRATE(TRATE),
    .NBITS(NBITS)
  ) u_addr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (clr),
    .adv_i (adv),
    .inc_i (ack_acc),
    .dev_o (dev),
    .slot_o(slot),
    .word_o(word),
    .last_o(last),
    .idx_o (idx)
  );

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    err_d   = err_q;
    wd_d    = wd_q;
    clr     = 1'b0;
    adv     = 1'b0;
    ack_acc = 1'b0;
    busy_o  = 1'b0;
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    done_o  = 1'b0;
    bst_o   = 1'b0;
`ifdef VIS_PREFETCH_BURST_EN
    out_d    = out_q;
    issued_d = issued_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bank_d = bank_i;
          err_d  = 1'b0;
          wd_d   = '0;
          clr    = 1'b1;
`ifdef VIS_PREFETCH_BURST_EN
          out_d    = '0;
          issued_d = 1'b0;
          state_d  = ST_BURST;
`else
          state_d  = ST_ISSUE;
`endif
        end
      end
`ifdef VIS_PREFETCH_BURST_EN
      ST_BURST: begin
        busy_o  = 1'b1;
        cyc_o   = 1'b1;
        bst_o   = 1'b1;
        stb_o   = !issued_q;
        ack_acc = ack_i && (out_q != '0);
        if (!issued_q) begin
          adv = 1'b1;
          if (last) issued_d = 1'b1;
        end
        out_d = out_q + {3'b000, stb_o} - {3'b000, ack_acc};
        // Watchdog restarts on every ack, so it measures silence since the last one.
        if (ack_acc) begin
          wd_d = '0;
        end else if (issued_q && out_q == '0) begin
          state_d = ST_FINISH;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
`else
      ST_ISSUE: begin
        busy_o  = 1'b1;
        cyc_o   = 1'b1;
        stb_o   = 1'b1;
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        cyc_o  = 1'b1;
        if (ack_i) begin
          ack_acc = 1'b1;
          adv     = 1'b1;
          state_d = last ? ST_FINISH : ST_ISSUE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
`endif
      ST_FINISH: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bank_q    <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
      buf_we_q  <= 1'b0;
      buf_adr_q <= '0;
      buf_dat_q <= '0;
`ifdef VIS_PREFETCH_BURST_EN
      out_q     <= '0;
      issued_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      buf_we_q <= ack_acc;
      if (ack_acc) begin
        buf_adr_q <= idx;
        buf_dat_q <= dat_i;
      end
`ifdef VIS_PREFETCH_BURST_EN
      out_q    <= out_d;
      issued_q <= issued_d;
`endif
    end
  end

  assign err_o     = err_q;
  assign we_o      = 1'b0;
  assign adr_o     = {dev, bank_q, slot, word};
  assign buf_we_o  = buf_we_q;
  assign buf_adr_o = buf_adr_q;
  assign buf_dat_o = buf_dat_q;
endmodule

// File: tb/tb_vis_prefetch.sv
// Scoreboard bench for vis_prefetch: randomized slave data, reference read/write sequence from arithmetic.
module tb_vis_prefetch;
  localparam int ACCUM  = 24;
  localparam int COUNT  = 2;
  localparam int BBITS  = 4;
  localparam int TBITS  = 4;
  localparam int TRATE  = 12;
  localparam int NBITS  = 8;
  localparam int ABITS  = 1 + BBITS + TBITS + 3;
  localparam int NREADS = COUNT * TRATE * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BBITS-1:0] bank = '0;
  logic             busy_o, done_o, err_o, cyc_o, stb_o, we_o, bst_o;
  logic             ack_i = 1'b0;
  logic [ABITS-1:0] adr_o;
  logic [ACCUM-1:0] dat_i = '0;
  logic             buf_we_o;
  logic [NBITS-1:0] buf_adr_o;
  logic [ACCUM-1:0] buf_dat_o;

  always #5 clk = ~clk;

  vis_prefetch dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bank_i(bank),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .we_o(we_o), .bst_o(bst_o), .ack_i(ack_i),
    .adr_o(adr_o), .dat_i(dat_i), .buf_we_o(buf_we_o),
    .buf_adr_o(buf_adr_o), .buf_dat_o(buf_dat_o)
  );

  typedef struct {
    int unsigned      badr;
    logic [ACCUM-1:0] dat;
  } wr_t;

  logic [ABITS-1:0] exp_adr_q[$];
  wr_t              exp_wr_q[$];
  logic [ABITS-1:0] strobe_log[NREADS];

  int          compared = 0, mismatched = 0;
  int unsigned salt = 0;
  int          skip_idx = -1;
  int          strobe_cnt = 0, done_cnt = 0, outst = 0, max_out = 0;
  int          cyc = 0, t_done = 0, t_err = 0, t_ack = 0, t_s9 = 0;
  bit          err_seen = 1'b0;
  bit               d1v = 1'b0, d2v = 1'b0;
  logic [ABITS-1:0] d1a = '0, d2a = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ACCUM-1:0] slave_data(input logic [ABITS-1:0] a);
    return ACCUM'((32'(a) * 32'h0001_9E37) ^ salt);
  endfunction

  // Reference: read i hits device i/(TRATE*8), slot (i/8)%TRATE, word i%8.
  function automatic logic [ABITS-1:0] model_adr(input int i, input int b);
    int dev, slot, word;
    dev  = i / (TRATE * 8);
    slot = (i / 8) % TRATE;
    word = i % 8;
    return ABITS'(dev * (1 << (BBITS + TBITS + 3)) + b * (1 << (TBITS + 3)) + slot * 8 + word);
  endfunction

  function automatic logic [63:0] all_outs();
    return {12'h0, busy_o, done_o, err_o, cyc_o, stb_o, we_o, bst_o, buf_we_o,
            adr_o, buf_adr_o, buf_dat_o};
  endfunction

  task automatic load_model(input int b, input int skip);
    int nstb, k;
    exp_adr_q.delete();
    exp_wr_q.delete();
`ifdef VIS_PREFETCH_BURST_EN
    nstb = NREADS;
`else
    nstb = (skip >= 0) ? skip + 1 : NREADS;
`endif
    k = 0;
    for (int i = 0; i < nstb; i++) begin
      exp_adr_q.push_back(model_adr(i, b));
      if (i != skip) begin
        exp_wr_q.push_back('{badr: k, dat: slave_data(model_adr(i, b))});
        k++;
      end
    end
  endtask

  // Slave (ack two cycles after each strobe) and output monitor share one process for ordering.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      d1v = 1'b0;
      d2v = 1'b0;
      ack_i = 1'b0;
    end else begin
      if (buf_we_o || ack_i) check("write trails ack", 64'(buf_we_o), 64'(ack_i));
      if (buf_we_o) begin
        if (exp_wr_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected buffer write: got adr %0d, expected none", buf_adr_o);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("buffer write {adr,dat}", {32'(buf_adr_o), 32'(buf_dat_o)}, {32'(e.badr), 32'(e.dat)});
        end
      end
      if (done_o) begin done_cnt++; t_done = cyc; end
      if (err_o && !err_seen) begin err_seen = 1'b1; t_err = cyc; end
      ack_i = d2v;
      dat_i = d2v ? slave_data(d2a) : ACCUM'($urandom);
      if (d2v) begin outst--; t_ack = cyc; end
      d2v = d1v;
      d2a = d1a;
      d1v = 1'b0;
      if (stb_o) begin
        if (strobe_cnt < NREADS) strobe_log[strobe_cnt] = adr_o;
        if (strobe_cnt == 9) t_s9 = cyc;
        if (exp_adr_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected strobe: got adr %0h, expected none", adr_o);
        end else begin
          check("strobe address", 64'(adr_o), 64'(exp_adr_q.pop_front()));
        end
`ifdef VIS_PREFETCH_BURST_EN
        if (!bst_o) check("bst during issue", 64'(bst_o), 64'd1);
`endif
        d1v = (strobe_cnt != skip_idx);
        d1a = adr_o;
        strobe_cnt++;
        outst++;
        if (outst > max_out) max_out = outst;
      end
    end
  end

  task automatic prep(input int b, input int skip);
    salt = $urandom;
    skip_idx = skip;
    load_model(b, skip);
    strobe_cnt = 0; done_cnt = 0; outst = 0; max_out = 0; err_seen = 1'b0;
  endtask

  task automatic pulse_start(input int b);
    start = 1'b1;
    bank = BBITS'(b);
    @(negedge clk);
    start = 1'b0;
    bank = BBITS'($urandom);
  endtask

  task automatic run_sweep(input int b, input int skip, output int t_start);
    bit ended;
    prep(b, skip);
    t_start = cyc;
    pulse_start(b);
    check("err cleared by start", 64'(err_o), 64'd0);
    ended = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt > 0 || err_o) begin ended = 1'b1; break; end
    end
    if (!ended) begin
      compared++; mismatched++;
      $display("FAIL sweep timeout: got no done/err, expected one within 3000 cycles");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_strobes(input int n);
    for (int i = 0; i < 2000 && strobe_cnt < n; i++) @(negedge clk);
    if (strobe_cnt < n) begin
      compared++; mismatched++;
      $display("FAIL strobe wait: got %0d strobes, expected %0d", strobe_cnt, n);
    end
  endtask

  initial begin
    int ts, b;
    repeat (3) @(negedge clk);
    check("reset outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle outputs", all_outs(), 64'd0);

    // Full sweep, bank 5
    run_sweep(5, -1, ts);
    check("done pulses", 64'(done_cnt), 64'd1);
    check("err after sweep", 64'(err_o), 64'd0);
    check("busy/cyc after sweep", {busy_o, cyc_o}, 64'd0);
    check("writes left", 64'(exp_wr_q.size()), 64'd0);
    check("strobes left", 64'(exp_adr_q.size()), 64'd0);
    check("read 95 address", 64'(strobe_log[95]), 64'({1'b0, 4'd5, 4'd11, 3'd7}));
    check("read 96 address", 64'(strobe_log[96]), 64'({1'b1, 4'd5, 4'd0, 3'd0}));
`ifdef VIS_PREFETCH_BURST_EN
    check("burst duration ok", 64'((t_done - ts) >= NREADS && (t_done - ts) <= NREADS + 10), 64'd1);
    check("max outstanding <= 3", 64'(max_out <= 3), 64'd1);
`else
    check("sweep duration ok", 64'((t_done - ts) >= NREADS * 2 && (t_done - ts) <= NREADS * 5), 64'd1);
`endif

    // Slave never acks the 10th read
    b = int'($urandom_range(15, 0));
    run_sweep(b, 9, ts);
    check("err on timeout", 64'(err_o), 64'd1);
    check("cyc/busy after timeout", {cyc_o, busy_o}, 64'd0);
    check("no done on timeout", 64'(done_cnt), 64'd0);
    check("writes left after timeout", 64'(exp_wr_q.size()), 64'd0);
`ifdef VIS_PREFETCH_BURST_EN
    check("timeout after last ack", 64'(t_err - t_ack), 64'd16);
`else
    check("timeout after 10th strobe", 64'(t_err - t_s9), 64'd16);
`endif

    // Recovery sweep
    b = int'($urandom_range(15, 0));
    run_sweep(b, -1, ts);
    check("recovery done", 64'(done_cnt), 64'd1);
    check("recovery err", 64'(err_o), 64'd0);
    check("recovery writes left", 64'(exp_wr_q.size()), 64'd0);

    // Re-pulse mid-sweep (ignored), then asynchronous reset at read 50
    prep(12, -1);
    pulse_start(12);
    wait_strobes(30);
    pulse_start(3);
    wait_strobes(50);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", all_outs(), 64'd0);
    @(negedge clk);
    check("no done across reset", 64'(done_cnt), 64'd0);
    exp_adr_q.delete();
    exp_wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("outputs after reset", all_outs(), 64'd0);
    run_sweep(9, -1, ts);
    check("post-reset done", 64'(done_cnt), 64'd1);
    check("post-reset writes left", 64'(exp_wr_q.size()), 64'd0);
    check("post-reset strobes left", 64'(exp_adr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
